fetch_sequencer: RTL and testbench

Program-counter owner and instruction-fetch sequencer for the single-issue core. Holds the PC, issues fetch requests to instruction memory over a req/ack handshake, and applies the `pc_sel`/`branch_sel` decision from branch control when decode issues an instruction. Also arbitrates the interrupt vector against normal flow and saves the return address.

---
 rtl/fetch_pkg.sv | 34 +++
 rtl/br_target.sv | 31 +++
 rtl/fetch_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and encodings for the instruction-fetch sequencer.
// Holds the sequencer state enum, the pc_sel/branch_sel encodings, the
// default reset/interrupt vectors, and the branch-offset scaling helper.
package fetch_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    // pc_sel encodings
    localparam logic [1:0] PC_SEL_RESET  = 2'b00;
    localparam logic [1:0] PC_SEL_IRQ    = 2'b01;
    localparam logic [1:0] PC_SEL_SEQ    = 2'b10;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b11;

    // branch_sel encodings
    localparam logic [1:0] BR_SEL_OFFSET = 2'b00;
    localparam logic [1:0] BR_SEL_REG    = 2'b01;
    localparam logic [1:0] BR_SEL_IMM    = 2'b10;
    localparam logic [1:0] BR_SEL_SEQ    = 2'b11;

    // Default vectors
    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_IRQ_VEC   = 32'h0000_0080;

    // Signed word offset to a byte offset: sign-extend and scale by 4.
    function automatic logic [31:0] offset_bytes(input logic [15:0] off);
        return {{14{off[15]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/br_target.sv
// br_target: combinational branch/jump target selection.
// Computes the redirect address from the decode PC and the branch operands.
// branch_sel=11 falls back to the sequential address pc+4.
module br_target
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [15:0] br_offset,
    input  logic [25:0] jmp_index,
    input  logic [31:0] jmp_reg,
    input  logic [1:0]  branch_sel,
    output logic [31:0] target
);

    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;

    // Select the redirect address for the current branch kind
    always_comb begin
        target = pc_plus4;
        unique case (branch_sel)
            BR_SEL_OFFSET: target = pc_plus4 + offset_bytes(br_offset);
            BR_SEL_REG:    target = jmp_reg;
            BR_SEL_IMM:    target = {pc_plus4[31:28], jmp_index, 2'b00};
            BR_SEL_SEQ:    target = pc_plus4;
            default:       target = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and instruction-fetch sequencer.
// BOOT -> FETCH (imem_req held until imem_ack) -> HOLD (instr_valid held
// until decode issues) -> FETCH ...  The next fetch address is chosen on
// issue with priority eret > interrupt > pc_sel decode.
//
// Handshake: imem_req rises with imem_addr and both stay constant until a
// cycle in which imem_ack=1 is sampled; imem_ack is ignored while
// imem_req=0.  instr_valid stays high with pc stable until a cycle in
// which issue=1 is sampled; issue is ignored outside HOLD.
//
// Optional feature macro: BR_DELAY_SLOT_EN (single branch delay slot).
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter logic [31:0] IRQ_VEC   = DEFAULT_IRQ_VEC
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   pc_sel,
    input  logic [1:0]   branch_sel,
    input  logic [15:0]  br_offset,
    input  logic [25:0]  jmp_index,
    input  logic [31:0]  jmp_reg,
    input  logic         issue,
    input  logic         eret,
    input  logic         irq,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ack,
    output logic         instr_valid,
    output logic [31:0]  pc,
    output logic [31:0]  link_addr,
    output logic [31:0]  epc,
    output logic         irq_taken,
    output fetch_state_t fsm_state
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic         irq_mask;
    logic [31:0]  pc_plus4;
    logic [31:0]  br_tgt;
    logic [31:0]  flow_next;
    logic [31:0]  next_pc;
    logic         take_irq;
    logic         is_redirect;

`ifdef BR_DELAY_SLOT_EN
    logic [31:0]  pend_pc;
    logic         pend_valid;
`endif

    assign pc_plus4  = pc + 32'd4;
    assign fsm_state = state;

`ifdef BR_DELAY_SLOT_EN
    // The delay-slot instruction sits between the branch and its return point
    assign link_addr = pc + 32'd8;
`else
    assign link_addr = pc_plus4;
`endif

    br_target u_br_target (
        .pc         (pc),
        .br_offset  (br_offset),
        .jmp_index  (jmp_index),
        .jmp_reg    (jmp_reg),
        .branch_sel (branch_sel),
        .target     (br_tgt)
    );

    // branch_sel=11 under pc_sel=11 is not a real redirect
    assign is_redirect = (pc_sel == PC_SEL_BRANCH) && (branch_sel != BR_SEL_SEQ);

    // Normal-flow address from pc_sel; with a delay slot a redirect first
    // fetches the sequential slot and parks the target in pend_pc.
    always_comb begin
        flow_next = pc_plus4;
        unique case (pc_sel)
            PC_SEL_RESET:  flow_next = RESET_VEC;
            PC_SEL_IRQ:    flow_next = IRQ_VEC;
            PC_SEL_SEQ:    flow_next = pc_plus4;
`ifdef BR_DELAY_SLOT_EN
            PC_SEL_BRANCH: flow_next = is_redirect ? pc_plus4 : br_tgt;
`else
            PC_SEL_BRANCH: flow_next = br_tgt;
`endif
            default:       flow_next = pc_plus4;
        endcase
    end

    // Interrupt acceptance; with a delay slot an interrupt is also refused on
    // the branch itself, since epc could not capture both slot and target.
    always_comb begin
`ifdef BR_DELAY_SLOT_EN
        take_irq = irq && !irq_mask && !eret && !pend_valid && !is_redirect;
`else
        take_irq = irq && !irq_mask && !eret;
`endif
    end

    // Final next-fetch priority: eret, pending delay-slot target, interrupt, flow
    always_comb begin
        next_pc = flow_next;
        if (eret) begin
            next_pc = epc;
`ifdef BR_DELAY_SLOT_EN
        end else if (pend_valid) begin
            next_pc = pend_pc;
`endif
        end else if (take_irq) begin
            next_pc = IRQ_VEC;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_BOOT;
            fetch_pc    <= RESET_VEC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_VEC;
            instr_valid <= 1'b0;
            pc          <= RESET_VEC;
            epc         <= 32'h0000_0000;
            irq_mask    <= 1'b0;
            irq_taken   <= 1'b0;
`ifdef BR_DELAY_SLOT_EN
            pend_pc     <= 32'h0000_0000;
            pend_valid  <= 1'b0;
`endif
        end else begin
            irq_taken <= 1'b0;
            unique case (state)
                ST_BOOT: begin
                    state     <= ST_FETCH;
                    fetch_pc  <= RESET_VEC;
                    imem_addr <= RESET_VEC;
                    imem_req  <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        pc          <= fetch_pc;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (issue) begin
                        fetch_pc    <= next_pc;
                        imem_addr   <= next_pc;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                        state       <= ST_FETCH;
                        if (eret) begin
                            irq_mask <= 1'b0;
                        end else if (take_irq) begin
                            epc       <= flow_next;
                            irq_mask  <= 1'b1;
                            irq_taken <= 1'b1;
                        end
`ifdef BR_DELAY_SLOT_EN
                        if (eret || pend_valid) begin
                            pend_valid <= 1'b0;
                        end else if (is_redirect) begin
                            pend_pc    <= br_tgt;
                            pend_valid <= 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state    <= ST_BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomised checks of fetch_sequencer.
// Expected fetch addresses are pushed when an issue is driven and popped
// when the DUT raises imem_req.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   pc_sel;
    logic [1:0]   branch_sel;
    logic [15:0]  br_offset;
    logic [25:0]  jmp_index;
    logic [31:0]  jmp_reg;
    logic         issue;
    logic         eret;
    logic         irq;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ack;
    logic         instr_valid;
    logic [31:0]  pc;
    logic [31:0]  link_addr;
    logic [31:0]  epc;
    logic         irq_taken;
    fetch_state_t fsm_state;

    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;

`ifdef BR_DELAY_SLOT_EN
    localparam logic [31:0] LINK_OFS = 32'd8;
`else
    localparam logic [31:0] LINK_OFS = 32'd4;
`endif

    fetch_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_sel      (pc_sel),
        .branch_sel  (branch_sel),
        .br_offset   (br_offset),
        .jmp_index   (jmp_index),
        .jmp_reg     (jmp_reg),
        .issue       (issue),
        .eret        (eret),
        .irq         (irq),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .instr_valid (instr_valid),
        .pc          (pc),
        .link_addr   (link_addr),
        .epc         (epc),
        .irq_taken   (irq_taken),
        .fsm_state   (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Memory driver: wait for a request, check it against the scoreboard,
    // hold it for lat cycles, then ack and check HOLD entry.
    task automatic serve_fetch(input int lat);
        int waited;
        logic [31:0] exp_addr;
        waited = 0;
        while (imem_req !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_vec++;
        if (imem_req !== 1'b1) begin
            $display("FAIL fetch_timeout: imem_req=%b after %0d cycles, required 1", imem_req, waited);
            n_fail++;
            return;
        end
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty: fetch of %h with nothing expected", imem_addr);
            n_fail++;
            return;
        end
        exp_addr = exp_q.pop_front();
        n_vec++;
        if (imem_addr !== exp_addr) begin
            $display("FAIL fetch_addr: got %h, required %h", imem_addr, exp_addr);
            n_fail++;
        end
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            n_vec++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
                $display("FAIL addr_stable: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, exp_addr);
                n_fail++;
            end
        end
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        n_vec++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== exp_addr) begin
            $display("FAIL hold_entry: valid=%b req=%b pc=%h, required valid=1 req=0 pc=%h",
                     instr_valid, imem_req, pc, exp_addr);
            n_fail++;
        end
        model_pc = exp_addr;
    endtask

    // Decode driver: one-cycle issue from HOLD, pushing the expected next fetch
    task automatic do_issue(input logic [1:0] sel, input logic [1:0] bsel,
                            input logic [15:0] off, input logic [25:0] idx,
                            input logic [31:0] rg, input logic er, input logic ir,
                            input logic [31:0] exp_next, input logic exp_taken);
        pc_sel     = sel;
        branch_sel = bsel;
        br_offset  = off;
        jmp_index  = idx;
        jmp_reg    = rg;
        eret       = er;
        irq        = ir;
        issue      = 1'b1;
        exp_q.push_back(exp_next);
        @(negedge clk);
        issue = 1'b0;
        eret  = 1'b0;
        irq   = 1'b0;
        n_vec++;
        if (irq_taken !== exp_taken) begin
            $display("FAIL irq_taken: got %b, required %b", irq_taken, exp_taken);
            n_fail++;
        end
    endtask

    // Taken branch/jump, including the delay-slot fetch when that build is used
    task automatic do_branch(input logic [1:0] bsel, input logic [15:0] off,
                             input logic [25:0] idx, input logic [31:0] rg,
                             input logic [31:0] exp_target, input int lat);
`ifdef BR_DELAY_SLOT_EN
        do_issue(PC_SEL_BRANCH, bsel, off, idx, rg, 1'b0, 1'b0, model_pc + 32'd4, 1'b0);
        serve_fetch(lat);
        do_issue(PC_SEL_SEQ, BR_SEL_SEQ, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, exp_target, 1'b0);
        serve_fetch(lat);
`else
        do_issue(PC_SEL_BRANCH, bsel, off, idx, rg, 1'b0, 1'b0, exp_target, 1'b0);
        serve_fetch(lat);
`endif
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || irq_taken !== 1'b0) begin
            $display("FAIL reset_flags: req=%b valid=%b taken=%b, required 0 0 0", imem_req, instr_valid, irq_taken);
            n_fail++;
        end
        n_vec++;
        if (imem_addr !== 32'h0 || pc !== 32'h0) begin
            $display("FAIL reset_addr: imem_addr=%h pc=%h, required 0 0", imem_addr, pc);
            n_fail++;
        end
        n_vec++;
        if (epc !== 32'h0) begin
            $display("FAIL reset_epc: got %h, required 0", epc);
            n_fail++;
        end
        n_vec++;
        if (fsm_state !== ST_BOOT) begin
            $display("FAIL reset_state: got %0d, required %0d", fsm_state, ST_BOOT);
            n_fail++;
        end
        n_vec++;
        if (link_addr !== LINK_OFS) begin
            $display("FAIL reset_link: got %h, required %h", link_addr, LINK_OFS);
            n_fail++;
        end
    endtask

    // Reset release with ack tied high and issue every HOLD: 0, 4, 8 two cycles apart
    task automatic test_boot_stream();
        int got;
        int cyc;
        int last;
        logic [31:0] e;
        got  = 0;
        last = 0;
        imem_ack = 1'b1;
        issue    = 1'b1;
        pc_sel   = PC_SEL_SEQ;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        reset_n = 1'b1;
        for (cyc = 1; cyc <= 20 && got < 3; cyc++) begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                e = exp_q.pop_front();
                n_vec++;
                if (imem_addr !== e) begin
                    $display("FAIL boot_addr: got %h, required %h", imem_addr, e);
                    n_fail++;
                end
                if (got > 0) begin
                    n_vec++;
                    if (cyc - last !== 2) begin
                        $display("FAIL boot_spacing: %0d cycles, required 2", cyc - last);
                        n_fail++;
                    end
                end
                last = cyc;
                got++;
            end
        end
        n_vec++;
        if (got != 3) begin
            $display("FAIL boot_timeout: saw %0d fetches, required 3", got);
            n_fail++;
            exp_q.delete();
        end
        @(negedge clk);
        issue    = 1'b0;
        imem_ack = 1'b0;
        n_vec++;
        if (instr_valid !== 1'b1 || pc !== 32'h8) begin
            $display("FAIL boot_hold: valid=%b pc=%h, required 1 00000008", instr_valid, pc);
            n_fail++;
        end
        model_pc = 32'h8;
    endtask

    task automatic test_branch_offset();
        do_branch(BR_SEL_REG, 16'h0, 26'h0, 32'h0000_0100, 32'h0000_0100, 1);
        n_vec++;
        if (link_addr !== 32'h0000_0100 + LINK_OFS) begin
            $display("FAIL link_offset: got %h, required %h", link_addr, 32'h0000_0100 + LINK_OFS);
            n_fail++;
        end
        do_branch(BR_SEL_OFFSET, 16'hFFFF, 26'h0, 32'h0, 32'h0000_0100, 2);
    endtask

    task automatic test_jump_imm();
        do_branch(BR_SEL_REG, 16'h0, 26'h0, 32'h4000_0010, 32'h4000_0010, 0);
        do_branch(BR_SEL_IMM, 16'h0, 26'h40, 32'h0, 32'h4000_0100, 1);
    endtask

    task automatic test_jump_reg();
        n_vec++;
        if (link_addr !== 32'h4000_0100 + LINK_OFS) begin
            $display("FAIL link_reg: got %h, required %h", link_addr, 32'h4000_0100 + LINK_OFS);
            n_fail++;
        end
        do_branch(BR_SEL_REG, 16'h0, 26'h0, 32'hDEAD_BEE0, 32'hDEAD_BEE0, 3);
    endtask

    // Vector selects and branch_sel=11 fallback
    task automatic test_vectors();
        do_issue(PC_SEL_RESET, BR_SEL_SEQ, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        serve_fetch(0);
        do_issue(PC_SEL_IRQ, BR_SEL_SEQ, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'h80, 1'b0);
        serve_fetch(1);
        do_issue(PC_SEL_BRANCH, BR_SEL_SEQ, 16'h1234, 26'h0, 32'h0, 1'b0, 1'b0, 32'h84, 1'b0);
        serve_fetch(0);
    endtask

    task automatic test_irq();
        do_branch(BR_SEL_REG, 16'h0, 26'h0, 32'h0000_0200, 32'h0000_0200, 0);
        do_issue(PC_SEL_SEQ, BR_SEL_SEQ, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 32'h80, 1'b1);
        @(negedge clk);
        n_vec++;
        if (irq_taken !== 1'b0) begin
            $display("FAIL irq_pulse_width: got %b, required 0", irq_taken);
            n_fail++;
        end
        serve_fetch(0);
        n_vec++;
        if (epc !== 32'h0000_0204) begin
            $display("FAIL epc_save: got %h, required 00000204", epc);
            n_fail++;
        end
        // Masked: second request flows sequentially
        do_issue(PC_SEL_SEQ, BR_SEL_SEQ, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 32'h84, 1'b0);
        serve_fetch(1);
        // eret beats a pending irq and returns to epc
        do_issue(PC_SEL_SEQ, BR_SEL_SEQ, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1, 32'h0000_0204, 1'b0);
        serve_fetch(0);
        // Mask cleared by eret
        do_issue(PC_SEL_SEQ, BR_SEL_SEQ, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 32'h80, 1'b1);
        serve_fetch(2);
        n_vec++;
        if (epc !== 32'h0000_0208) begin
            $display("FAIL epc_resave: got %h, required 00000208", epc);
            n_fail++;
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        logic [15:0] off;
        for (int i = 0; i < 6; i++) begin
            tgt = $urandom & 32'hFFFF_FFFC;
            do_branch(BR_SEL_REG, 16'h0, 26'h0, tgt, tgt, $urandom_range(0, 3));
            off = 16'($urandom_range(0, 16'hFFFF));
            tgt = model_pc + 32'd4 + {{14{off[15]}}, off, 2'b00};
            do_branch(BR_SEL_OFFSET, off, 26'h0, 32'h0, tgt, $urandom_range(0, 3));
        end
    endtask

    // Reset mid-fetch with a late ack
    task automatic test_reset_abort();
        logic [31:0] e;
        do_issue(PC_SEL_SEQ, BR_SEL_SEQ, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, model_pc + 32'd4, 1'b0);
        e = exp_q.pop_front();
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== e) begin
            $display("FAIL abort_pre: req=%b addr=%h, required 1 %h", imem_req, imem_addr, e);
            n_fail++;
        end
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if (imem_req !== 1'b0 || fsm_state !== ST_BOOT || imem_addr !== 32'h0) begin
            $display("FAIL abort_drop: req=%b state=%0d addr=%h, required 0 %0d 0",
                     imem_req, fsm_state, imem_addr, ST_BOOT);
            n_fail++;
        end
        imem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            $display("FAIL abort_ack_ignored: req=%b valid=%b, required 0 0", imem_req, instr_valid);
            n_fail++;
        end
        imem_ack = 1'b0;
        reset_n  = 1'b1;
        exp_q.push_back(32'h0);
        serve_fetch(1);
        n_vec++;
        if (epc !== 32'h0) begin
            $display("FAIL abort_epc: got %h, required 0", epc);
            n_fail++;
        end
        // irq_mask was set before the reset; it must now be clear
        do_issue(PC_SEL_SEQ, BR_SEL_SEQ, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 32'h80, 1'b1);
        serve_fetch(0);
        n_vec++;
        if (epc !== 32'h4) begin
            $display("FAIL abort_irq_epc: got %h, required 00000004", epc);
            n_fail++;
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        pc_sel     = PC_SEL_SEQ;
        branch_sel = BR_SEL_SEQ;
        br_offset  = 16'h0;
        jmp_index  = 26'h0;
        jmp_reg    = 32'h0;
        issue      = 1'b0;
        eret       = 1'b0;
        irq        = 1'b0;
        imem_ack   = 1'b0;
        model_pc   = 32'h0;

        test_reset();
        test_boot_stream();
        test_branch_offset();
        test_jump_imm();
        test_jump_reg();
        test_vectors();
        test_irq();
        test_random();
        test_reset_abort();

        n_vec++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
            n_fail++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
